// File: rtl/msk_rnd_pkg.sv
// Shared types and LFSR constants for the masked-gadget randomness bank.
// Pure declarations, no latency; no handshake.
// Backpressure: not applicable.
package msk_rnd_pkg;

    typedef enum logic [1:0] {
        SEED = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int LANE_W = 31;
    localparam int TAP_HI = 30;
    localparam int TAP_LO = 27;

    localparam logic [LANE_W-1:0] ZERO_SEED_SUB = 31'h1;

    // x^31 + x^28 + 1, shifting toward the MSB with feedback into bit 0
    function automatic logic [LANE_W-1:0] lfsr_next(input logic [LANE_W-1:0] s);
        return {s[LANE_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
    endfunction

endpackage

// File: rtl/msk_lfsr31.sv
// One 31-bit Fibonacci LFSR lane with synchronous load and step enables.
// Latency: load/step take effect on the next rising edge; bit_o is registered.
// Backpressure: none; the lane only advances when step is asserted.
module msk_lfsr31
    import msk_rnd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LANE_W-1:0] load_val,
    input  logic              step,
    output logic              bit_o
);

    logic [LANE_W-1:0] lane_q;
    logic [LANE_W-1:0] lane_d;

    always_comb begin
        lane_d = lane_q;
        if (load) begin
            lane_d = load_val;
        end else if (step) begin
            lane_d = lfsr_next(lane_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q <= ZERO_SEED_SUB;
        end else begin
            lane_q <= lane_d;
        end
    end

    assign bit_o = lane_q[0];

endmodule

// File: rtl/msk_rnd_lfsr_bank.sv
// Bank of NRND LFSR lanes feeding fresh randomness to masked gadgets.
// Latency: valid 1+WARMUP cycles after the last seed word; one transfer per cycle after that.
// Backpressure: lanes hold (no step) while rnd_valid & !rnd_ready, so no bit is delivered twice.
module msk_rnd_lfsr_bank
    import msk_rnd_pkg::*;
#(
    parameter int NRND   = 2,
    parameter int WARMUP = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     seed_in,
    input  logic            seed_valid,
    output logic            seed_ready,
    input  logic            reseed,
    output logic [NRND-1:0] rnd_out,
    output logic            rnd_valid,
    input  logic            rnd_ready
);

    localparam int IDX_W = (NRND > 1) ? $clog2(NRND) : 1;
    localparam int CNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NRND - 1);
    localparam logic [CNT_W-1:0] WARM_MAX  = CNT_W'(WARMUP);
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NRND-1:0]   load_en;
    logic [NRND-1:0]   lane_bit;
    logic              step_all;
    logic              seed_acc;
    logic [LANE_W-1:0] load_val;
    logic              unused_seed_msb;

    assign unused_seed_msb = seed_in[31];
    assign load_val = (seed_in[LANE_W-1:0] == '0) ? ZERO_SEED_SUB : seed_in[LANE_W-1:0];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = '0;
        step_all   = 1'b0;
        seed_acc   = 1'b0;
        seed_ready = 1'b0;
        rnd_valid  = 1'b0;
        case (state_q)
            SEED: begin
                seed_ready = 1'b1;
                if (reseed) begin
                    // a word arriving alongside reseed is dropped, not loaded
                    idx_d = '0;
                end else if (seed_valid) begin
                    seed_acc = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (WARMUP > 0) ? WARM : RUN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            WARM: begin
                if (reseed) begin
                    state_d = SEED;
                    idx_d   = '0;
                end else begin
                    step_all = 1'b1;
                    cnt_d    = (cnt_q == WARM_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    if (cnt_q == WARM_LAST) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rnd_valid = 1'b1;
                if (reseed) begin
                    state_d = SEED;
                    idx_d   = '0;
                end else if (rnd_ready) begin
                    step_all = 1'b1;
                end
            end
            default: begin
                state_d = SEED;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        load_en = '0;
        for (int i = 0; i < NRND; i++) begin
            load_en[i] = seed_acc && (idx_q == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar g = 0; g < NRND; g++) begin : g_lane
        msk_lfsr31 u_lane (
            .clk      (clk),
            .rst      (rst),
            .load     (load_en[g]),
            .load_val (load_val),
            .step     (step_all),
            .bit_o    (lane_bit[g])
        );
    end

    // lanes reset to 1, so gate the output to keep it zero until a stream is released
    assign rnd_out = (state_q == RUN) ? lane_bit : '0;

endmodule

// File: tb/tb_msk_rnd_lfsr_bank.sv
// Randomized bench for msk_rnd_lfsr_bank: two instances (WARMUP=0 and WARMUP=64)
// checked against an arithmetic LFSR reference model.
module tb_msk_rnd_lfsr_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] seed_in    [2];
    logic        seed_valid [2];
    logic        seed_ready [2];
    logic        reseed     [2];
    logic [1:0]  rnd_out    [2];
    logic        rnd_valid  [2];
    logic        rnd_ready  [2];

    longint unsigned m_lane [2][2];
    int n_chk  = 0;
    int n_fail = 0;
    int ones0  = 0;

    always #5 clk = ~clk;

    msk_rnd_lfsr_bank #(.NRND(2), .WARMUP(0)) dut0 (
        .clk(clk), .rst(rst), .seed_in(seed_in[0]), .seed_valid(seed_valid[0]),
        .seed_ready(seed_ready[0]), .reseed(reseed[0]), .rnd_out(rnd_out[0]),
        .rnd_valid(rnd_valid[0]), .rnd_ready(rnd_ready[0])
    );

    msk_rnd_lfsr_bank #(.NRND(2), .WARMUP(64)) dut1 (
        .clk(clk), .rst(rst), .seed_in(seed_in[1]), .seed_valid(seed_valid[1]),
        .seed_ready(seed_ready[1]), .reseed(reseed[1]), .rnd_out(rnd_out[1]),
        .rnd_valid(rnd_valid[1]), .rnd_ready(rnd_ready[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: shift left by one within 31 bits, new bit 0 = s[30] xor s[27]
    function automatic longint unsigned ref_step(input longint unsigned s);
        longint unsigned fb;
        fb = ((s >> 30) ^ (s >> 27)) % 2;
        return (s * 2 + fb) % (64'd1 << 31);
    endfunction

    function automatic logic [1:0] exp_bits(input int d);
        return {1'(m_lane[d][1] % 2), 1'(m_lane[d][0] % 2)};
    endfunction

    task automatic model_step(input int d);
        for (int i = 0; i < 2; i++) m_lane[d][i] = ref_step(m_lane[d][i]);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 2; i++) m_lane[d][i] = 1;
    endtask

    // Returns at the negedge of the cycle after the last seed was accepted
    task automatic load_seeds(input int d, input logic [31:0] w0, input logic [31:0] w1);
        logic [31:0] w;
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? w0 : w1;
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                seed_valid[d] = 1'b0;
                seed_in[d]    = $urandom;
            end
            @(negedge clk);
            chk("seed_ready", seed_ready[d], 1);
            seed_valid[d] = 1'b1;
            seed_in[d]    = w;
            m_lane[d][k]  = (w % (64'd1 << 31) == 0) ? 1 : longint'(w % (64'd1 << 31));
        end
        @(negedge clk);
        seed_valid[d] = 1'b0;
    endtask

    // mode 0: random ready, 1: ready held high, 2: ready held low
    task automatic run_xfers(input int d, input int n, input int mode);
        logic r;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rnd_valid", rnd_valid[d], 1);
            chk("rnd_out", rnd_out[d], exp_bits(d));
            if (d == 0) ones0 += int'(rnd_out[0][0]);
            r = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            rnd_ready[d] = r;
            if (r) model_step(d);
        end
        @(negedge clk);
        rnd_ready[d] = 1'b0;
    endtask

    task automatic reseed_with_xfer(input int d);
        @(negedge clk);
        chk("pre_reseed_out", rnd_out[d], exp_bits(d));
        rnd_ready[d] = 1'b1;
        reseed[d]    = 1'b1;
        @(negedge clk);
        rnd_ready[d] = 1'b0;
        reseed[d]    = 1'b0;
        chk("reseed_valid", rnd_valid[d], 0);
        chk("reseed_seed_ready", seed_ready[d], 1);
    endtask

    task automatic wait_warm(input int d, input int want);
        int cnt;
        cnt = 1;
        rnd_ready[d]  = 1'b1;
        seed_valid[d] = 1'b1;
        seed_in[d]    = $urandom;
        while (!rnd_valid[d] && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        rnd_ready[d]  = 1'b0;
        seed_valid[d] = 1'b0;
        chk("warm_latency", 64'(cnt), 64'(want));
        repeat (64) model_step(d);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            seed_in[d] = '0; seed_valid[d] = 1'b0; reseed[d] = 1'b0; rnd_ready[d] = 1'b0;
        end
        model_reset();
        #3;
        for (int d = 0; d < 2; d++) begin
            chk("rst_seed_ready", seed_ready[d], 1);
            chk("rst_valid", rnd_valid[d], 0);
            chk("rst_out", rnd_out[d], 0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed first stream, WARMUP=0
        load_seeds(0, 32'h0000_0001, 32'h0000_0003);
        chk("first_valid", rnd_valid[0], 1);
        chk("first_out", rnd_out[0], 2'b11);
        rnd_ready[0] = 1'b1;
        model_step(0);
        @(negedge clk);
        rnd_ready[0] = 1'b0;
        chk("second_out", rnd_out[0], 2'b00);
        run_xfers(0, 50, 0);

        // Reseed with coincident transfer, then a reseed while loading
        reseed_with_xfer(0);
        @(negedge clk);
        seed_valid[0] = 1'b1; seed_in[0] = $urandom;
        @(negedge clk);
        seed_in[0] = $urandom; reseed[0] = 1'b1;
        @(negedge clk);
        seed_valid[0] = 1'b0; reseed[0] = 1'b0;
        chk("seed_reseed_valid", rnd_valid[0], 0);

        // All-zero seed substitution, stream must not be stuck
        load_seeds(0, 32'h8000_0000, $urandom);
        chk("zero_sub_bit", rnd_out[0][0], 1);
        ones0 = 0;
        run_xfers(0, 100, 1);
        chk("not_stuck", (ones0 > 0) ? 1 : 0, 1);

        // WARMUP=64 latency and first 32 bits
        load_seeds(1, $urandom, $urandom);
        wait_warm(1, 65);
        run_xfers(1, 32, 1);
        run_xfers(1, 10, 2);
        run_xfers(1, 40, 0);

        // Reseed in RUN on the long-warmup instance, then async reset mid-WARM
        reseed_with_xfer(1);
        load_seeds(1, $urandom, $urandom);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_seed_ready", seed_ready[1], 1);
        chk("arst_valid1", rnd_valid[1], 0);
        chk("arst_valid0", rnd_valid[0], 0);
        chk("arst_out0", rnd_out[0], 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        load_seeds(0, $urandom, $urandom);
        run_xfers(0, 40, 0);
        load_seeds(1, $urandom, $urandom);
        wait_warm(1, 65);
        run_xfers(1, 40, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/msk_rnd_lfsr_bank.md
Name: msk_rnd_lfsr_bank

Overview:
- Fresh-randomness source for masked gadgets (HPC1 AND, SNI refresh, DOM AND).
- Drives their rnd bus directly upstream.
- Bank of NRND independent 31-bit LFSR lanes, seeded over a 32-bit word handshake, with a warm-up phase before bits are released.
- Valid/ready output so no random bit is ever delivered twice; reseed supported mid-operation.

Parameters:
- NRND, 2, number of random bits per transfer (set to the consuming gadget's hpc1rnd count).
- WARMUP, 64, LFSR steps discarded after seeding before rnd_valid rises (0 allowed).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- seed_in  input  32  seed word; bits [30:0] load one lane, bit 31 ignored.
- seed_valid  input  1  seed word present.
- seed_ready  output  1  block accepts a seed word this cycle.
- reseed  input  1  single-cycle request to discard state and reseed.
- rnd_out  output  NRND  random bits, bit i = lane i.
- rnd_valid  output  1  rnd_out is fresh.
- rnd_ready  input  1  consumer takes rnd_out this cycle.

Behaviour:
- States: SEED, WARM, RUN.
- Reset (async, immediate):
  - state=SEED, seed index=0, warm counter=0.
  - every lane=31'h1.
  - seed_ready=1, rnd_valid=0, rnd_out=0.
- Lane step (used in WARM and on RUN transfers): next = {s[29:0], s[30]^s[27]}, polynomial x^31+x^28+1; lane output bit = s[0].
- SEED:
  - seed_ready=1; rnd_valid=0.
  - On seed_valid&seed_ready: lane[idx] <= seed_in[30:0], with all-zero replaced by 31'h1; idx++.
  - After lane NRND-1 is loaded: idx<=0; go to WARM (WARMUP>0) or RUN (WARMUP=0).
  - reseed in SEED: restarts loading at idx=0; any word accepted that cycle is discarded.
- WARM:
  - seed_ready=0, rnd_valid=0.
  - All lanes step every cycle; counter increments.
  - After exactly WARMUP steps, go to RUN.
- RUN:
  - rnd_valid=1; rnd_out = bit 0 of each lane, registered, stable while valid&!ready.
  - On rnd_valid&rnd_ready: all lanes step once; the next rnd_out appears the following cycle with no bubble (one transfer per cycle sustained).
  - No step without ready.
- reseed in WARM or RUN:
  - Next cycle: state=SEED, idx=0, rnd_valid=0, lane contents retained until overwritten.
  - A transfer coinciding with reseed completes (consumer got the bit), but lanes do not step.
- Latency:
  - Last seed word accepted at cycle t: rnd_valid=1 at t+1+WARMUP.
  - Transfer at t: next bits valid at t+1.
- seed_valid while seed_ready=0: ignored, no state change.
- Widths:
  - idx is clog2(NRND) bits (min 1).
  - Warm counter is clog2(WARMUP+1) bits and saturates; no wrap.
- Reset asserted mid-load or mid-RUN: all of the above reset values apply immediately; partially loaded seeds are lost.

Decomposition:
- Package msk_rnd_pkg:
  - state enum (SEED, WARM, RUN).
  - LANE_W=31, TAP_HI=30, TAP_LO=27.
  - ZERO_SEED_SUB=31'h1.
- Sub-module msk_lfsr31:
  - one lane with load, load_val, step inputs and 31-bit state, plus bit-0 output.
  - Instantiated NRND times via generate.
- FSM, index and counter live in the top module.

Test Plan:
- Reset then NRND=2, WARMUP=0: seeds 0x00000001 and 0x00000003 -> rnd_valid next cycle, rnd_out=2'b11. One transfer -> lanes 0x2, 0x6, rnd_out=2'b00.
- Seed word 0x80000000 (bits [30:0] zero), WARMUP=0 -> lane loaded with 31'h1, rnd_out[0]=1, never a stuck-zero stream over 100 transfers.
- WARMUP=64, hold rnd_ready=1 -> rnd_valid rises exactly 65 cycles after last seed accept. First 32 bits per lane match the golden LFSR model advanced 64 steps.
- rnd_ready=0 for 10 cycles in RUN -> rnd_out constant, lane state unchanged. Then ready=1 -> sequence continues with no skipped or repeated bit.
- reseed pulsed with rnd_valid&rnd_ready -> transfer counted, rnd_valid=0 next cycle, seed_ready=1, idx=0. New seeds produce the new stream.
- Async rst asserted mid-WARM, between clock edges -> rnd_valid=0 and seed_ready=1 immediately. The first seed after release loads lane 0.
